// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Produces stall/flush controls for PC, IF/ID, ID/EX and EX/MEM, sequences
// the post-redirect flush window that covers instruction-memory latency,
// and keeps saturating performance counters.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   id_valid, id_rs1, id_rs2,
//   id_rs2_used               decode-stage instruction and its source selects
//   ex_mem_read, ex_rd,
//   ex_redirect               EX-stage load status, destination, redirect
//   mem_busy                  data memory cannot complete this cycle
//   perf_clr                  clear both performance counters
//   pc_stall .. exmem_stall   pipeline controls (combinational, same cycle)
//   stall_cycles              cycles with pc_stall=1 (saturating)
//   flush_events              accepted redirects (saturating)
module hazard_ctrl #(
   parameter int unsigned REG_SEL  = 5,
   parameter int unsigned IMEM_LAT = 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [REG_SEL-1:0] id_rs1,
   input  logic [REG_SEL-1:0] id_rs2,
   input  logic               id_rs2_used,
   input  logic               ex_mem_read,
   input  logic [REG_SEL-1:0] ex_rd,
   input  logic               ex_redirect,
   input  logic               mem_busy,
   input  logic               perf_clr,
   output logic               pc_stall,
   output logic               ifid_stall,
   output logic               ifid_flush,
   output logic               idex_stall,
   output logic               idex_flush,
   output logic               exmem_stall,
   output logic [CNT_W-1:0]   stall_cycles,
   output logic [CNT_W-1:0]   flush_events
);

   localparam logic [2:0]       FLUSH_LEN = 3'(IMEM_LAT);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   state_t     state;
   state_t     ret_state;
   state_t     eff_state;
   logic [2:0] fcnt;
   logic       load_use;
   logic       redirect_taken;

   // Leaving MEM_WAIT, the cycle behaves as if already back in the saved state.
   assign eff_state = (state == MEM_WAIT) ? ret_state : state;

   // x0 is never a real producer, so ex_rd==0 cannot create a hazard.
   assign load_use = id_valid && ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (id_rs2_used && (ex_rd == id_rs2)));

   assign redirect_taken = rst && !mem_busy && ex_redirect;

   // Mealy control outputs, highest priority first.
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_flush  = 1'b0;
      exmem_stall = 1'b0;
      if (!rst) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (mem_busy) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
      end else if (ex_redirect) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (eff_state == FLUSH) begin
         ifid_flush = 1'b1;
      end else if (load_use) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_flush = 1'b1;
      end
   end

   // Sequencer state, flush counter and performance counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= RUN;
         ret_state    <= RUN;
         fcnt         <= 3'd0;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (mem_busy) begin
            // Re-entry from MEM_WAIT keeps the originally saved state.
            if (state != MEM_WAIT) begin
               ret_state <= state;
            end
            state <= MEM_WAIT;
         end else if (ex_redirect) begin
            if (IMEM_LAT > 0) begin
               state <= FLUSH;
               fcnt  <= FLUSH_LEN;
            end else begin
               state <= RUN;
            end
         end else if (eff_state == FLUSH) begin
            fcnt  <= fcnt - 3'd1;
            state <= (fcnt == 3'd1) ? RUN : FLUSH;
         end else begin
            state <= RUN;
         end

         if (perf_clr) begin
            stall_cycles <= '0;
            flush_events <= '0;
         end else begin
            if (pc_stall && (stall_cycles != CNT_MAX)) begin
               stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (redirect_taken && (flush_events != CNT_MAX)) begin
               flush_events <= flush_events + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random
// traffic, compared against a behavioural model that tracks only the
// number of stale fetches still to be discarded.
module tb_hazard_ctrl;

   localparam int unsigned IMEM_LAT = 1;
   localparam int unsigned CNT_W    = 16;
   localparam int          CNT_MAX  = (1 << CNT_W) - 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_rs2_used, ex_mem_read, ex_redirect, mem_busy, perf_clr;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall;
   logic [CNT_W-1:0] stall_cycles, flush_events;

   int checks   = 0;
   int failures = 0;

   // model state
   int m_stale = 0;
   int m_sc    = 0;
   int m_fe    = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_SEL(5), .IMEM_LAT(IMEM_LAT), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs2_used  (id_rs2_used),
      .ex_mem_read  (ex_mem_read),
      .ex_rd        (ex_rd),
      .ex_redirect  (ex_redirect),
      .mem_busy     (mem_busy),
      .perf_clr     (perf_clr),
      .pc_stall     (pc_stall),
      .ifid_stall   (ifid_stall),
      .ifid_flush   (ifid_flush),
      .idex_stall   (idex_stall),
      .idex_flush   (idex_flush),
      .exmem_stall  (exmem_stall),
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, check before the next posedge,
   // then advance the model to the post-edge state.
   // Control vector order: pc, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem.
   task automatic cycle(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic used, input logic mr, input logic [4:0] rd,
                        input logic redir, input logic busy, input logic clr,
                        input logic r);
      logic [5:0] e;
      logic       lu;
      @(negedge clk);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs2_used = used;
      ex_mem_read = mr; ex_rd = rd; ex_redirect = redir;
      mem_busy = busy; perf_clr = clr; rst = r;
      #1;
      lu = v && mr && (rd != 5'd0) && ((rd == rs1) || (used && (rd == rs2)));
      if (!r)              e = 6'b001010;
      else if (busy)       e = 6'b110101;
      else if (redir)      e = 6'b001010;
      else if (m_stale > 0) e = 6'b001000;
      else if (lu)         e = 6'b110010;
      else                 e = 6'b000000;
      check("ctl", 32'({pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall}),
            32'(e));
      check("stall_cycles", 32'(stall_cycles), 32'(m_sc));
      check("flush_events", 32'(flush_events), 32'(m_fe));
      if (!r) begin
         m_stale = 0; m_sc = 0; m_fe = 0;
      end else begin
         if (clr) begin
            m_sc = 0; m_fe = 0;
         end else begin
            if (e[5] && m_sc < CNT_MAX) m_sc++;
            if (!busy && redir && m_fe < CNT_MAX) m_fe++;
         end
         if (!busy) begin
            if (redir)            m_stale = int'(IMEM_LAT);
            else if (m_stale > 0) m_stale--;
         end
      end
   endtask

   task automatic idle();
      cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic busy_cycle();
      cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic redirect_cycle();
      cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs2_used = 1'b0;
      ex_mem_read = 1'b0; ex_rd = '0; ex_redirect = 1'b0; mem_busy = 1'b0; perf_clr = 1'b0;
      repeat (2) @(posedge clk);

      // reset state
      cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      idle();

      // load-use on rs1
      cycle(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      // x0 never hazards
      cycle(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      // rs2 match but rs2 unused
      cycle(1'b1, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
      // rs2 match and used
      cycle(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();

      // redirect then flush window
      redirect_cycle();
      idle();
      idle();

      // redirect, then three busy cycles, then resume flush
      redirect_cycle();
      repeat (3) busy_cycle();
      idle();
      idle();

      // redirect together with load-use: flushes win
      cycle(1'b1, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      idle();
      idle();

      // reset in the middle of a flush window and of a memory wait
      redirect_cycle();
      cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      redirect_cycle();
      busy_cycle();
      cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle();

      // saturate stall_cycles, then clear with a concurrent stall
      repeat (CNT_MAX + 3) busy_cycle();
      cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      idle();

      // random traffic with small register range to hit matches often
      for (int i = 0; i < 4000; i++) begin
         cycle(1'($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)),
               1'($urandom_range(0, 6) == 0),
               1'($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 40) == 0),
               1'($urandom_range(0, 60) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
